// File: rtl/max_pool_relu_layer.sv
// max_pool_relu_layer
// 2x2 / stride-2 max pooling followed by ReLU over CHANNELS flattened FP16
// feature maps. The whole input is snapshotted when a pass starts; one
// output row is then produced per cycle for all channels in parallel.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      begin a pass on the current convIn (only honoured in IDLE)
//   convIn     input maps, element (c,r,x) at bit ((c*H+r)*W+x)*DATA_WIDTH
//   outputPool registered result, element (c,r,x) at ((c*HO+r)*WO+x)*DATA_WIDTH
//   busy       high while a pass is running (POOL and DONE)
//   done       one-cycle pulse once every output row has been written
module max_pool_relu_layer #(
    parameter int DATA_WIDTH = 16,
    parameter int H          = 28,
    parameter int W          = 28,
    parameter int CHANNELS   = 6
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic [CHANNELS*H*W*DATA_WIDTH-1:0]            convIn,
    output logic [CHANNELS*(H/2)*(W/2)*DATA_WIDTH-1:0]    outputPool,
    output logic                                          busy,
    output logic                                          done
);

    localparam int HO       = H / 2;
    localparam int WO       = W / 2;
    localparam int IN_BITS  = CHANNELS * H * W * DATA_WIDTH;
    localparam int OUT_BITS = CHANNELS * HO * WO * DATA_WIDTH;
    localparam int RW       = (HO > 1) ? $clog2(HO) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(HO - 1);

    typedef enum logic [1:0] {
        IDLE,
        POOL,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [IN_BITS-1:0]    snap_q, snap_d;
    logic [OUT_BITS-1:0]   pool_q, pool_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] top_row [CHANNELS][2*WO];
    logic [DATA_WIDTH-1:0] bot_row [CHANNELS][2*WO];
    logic [DATA_WIDTH-1:0] row_val [CHANNELS][WO];
    logic [DATA_WIDTH-1:0] win_max;

    // Sign-magnitude FP16 maximum. Zeros of either sign tie and keep 'a';
    // NaN/Inf are ordered purely by their bit patterns.
    function automatic logic [DATA_WIDTH-1:0] fp_max(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic                  a_neg, b_neg;
        logic [DATA_WIDTH-2:0] a_mag, b_mag;
        a_neg = a[DATA_WIDTH-1];
        b_neg = b[DATA_WIDTH-1];
        a_mag = a[DATA_WIDTH-2:0];
        b_mag = b[DATA_WIDTH-2:0];
        if ((a_mag == '0) && (b_mag == '0)) begin
            return a;
        end else if (a_neg != b_neg) begin
            return a_neg ? b : a;
        end else if (!a_neg) begin
            return (b_mag > a_mag) ? b : a;
        end else begin
            return (b_mag < a_mag) ? b : a;
        end
    endfunction

    // Pick the pair of snapshot rows feeding the current output row, so only
    // one row's worth of comparators is needed.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            for (int x = 0; x < 2*WO; x++) begin
                top_row[c][x] = '0;
                bot_row[c][x] = '0;
            end
        end
        for (int r = 0; r < HO; r++) begin
            if (row_q == RW'(r)) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    for (int x = 0; x < 2*WO; x++) begin
                        top_row[c][x] = snap_q[((c*H + 2*r)   * W + x) * DATA_WIDTH +: DATA_WIDTH];
                        bot_row[c][x] = snap_q[((c*H + 2*r+1) * W + x) * DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Fixed comparison tree max(max(a,b), max(c,d)) then ReLU; -0 clamps to +0.
    always_comb begin
        win_max = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int x = 0; x < WO; x++) begin
                win_max = fp_max(fp_max(top_row[c][2*x], top_row[c][2*x+1]),
                                 fp_max(bot_row[c][2*x], bot_row[c][2*x+1]));
                row_val[c][x] = win_max[DATA_WIDTH-1] ? '0 : win_max;
            end
        end
    end

    // Next-state logic: capture on start, write one row per POOL cycle,
    // then spend a single DONE cycle before accepting another start.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        snap_d  = snap_q;
        pool_d  = pool_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = convIn;
                    row_d   = '0;
                    state_d = POOL;
                end
            end
            POOL: begin
                for (int r = 0; r < HO; r++) begin
                    if (row_q == RW'(r)) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            for (int x = 0; x < WO; x++) begin
                                pool_d[((c*HO + r) * WO + x) * DATA_WIDTH +: DATA_WIDTH] = row_val[c][x];
                            end
                        end
                    end
                end
                if (row_q == LAST_ROW) begin
                    state_d = DONE;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State register; reset also wipes a partially written result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            snap_q  <= '0;
            pool_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            snap_q  <= snap_d;
            pool_q  <= pool_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign outputPool = pool_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_max_pool_relu_layer.sv
// tb_max_pool_relu_layer
// Scoreboard bench for max_pool_relu_layer: stimulus pushes the expected
// result and done cycle for each accepted start; a negedge monitor pops and
// compares whenever done pulses.
module tb_max_pool_relu_layer;

    localparam int DW       = 16;
    localparam int H        = 28;
    localparam int W        = 28;
    localparam int C        = 6;
    localparam int HO       = H / 2;
    localparam int WO       = W / 2;
    localparam int IN_BITS  = C * H * W * DW;
    localparam int OUT_BITS = C * HO * WO * DW;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [IN_BITS-1:0]  convIn;
    logic [OUT_BITS-1:0] outputPool;
    logic                busy;
    logic                done;

    typedef struct {
        logic [OUT_BITS-1:0] data;
        int                  done_cycle;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   passes   = 0;
    int   cyc      = 0;
    int   busy_run = 0;

    max_pool_relu_layer #(
        .DATA_WIDTH (DW),
        .H          (H),
        .W          (W),
        .CHANNELS   (C)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .convIn     (convIn),
        .outputPool (outputPool),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Count rising edges so done timing can be checked against the start edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Non-negative integer to FP16 with truncation; monotonic, which is all
    // the ramp tests rely on.
    function automatic logic [15:0] int_to_fp16(input int n);
        int         e;
        int         frac;
        logic [4:0] ef;
        logic [9:0] ff;
        if (n == 0) return 16'h0000;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        if (e >= 10) frac = n >> (e - 10);
        else         frac = n << (10 - e);
        ef = 5'(e + 15);
        ff = 10'(frac & 32'h3FF);
        return {1'b0, ef, ff};
    endfunction

    function automatic logic [IN_BITS-1:0] ramp_map(input int k);
        logic [IN_BITS-1:0] m;
        m = '0;
        for (int c = 0; c < C; c++)
            for (int r = 0; r < H; r++)
                for (int x = 0; x < W; x++)
                    m[((c*H + r)*W + x)*DW +: DW] = int_to_fp16(c*1000 + r*28 + x + k*5000);
        return m;
    endfunction

    // Ramp values grow with row then column, so each window's max is its
    // bottom-right element.
    function automatic logic [OUT_BITS-1:0] ramp_expect(input logic [IN_BITS-1:0] m);
        logic [OUT_BITS-1:0] o;
        o = '0;
        for (int c = 0; c < C; c++)
            for (int r = 0; r < HO; r++)
                for (int x = 0; x < WO; x++)
                    o[((c*HO + r)*WO + x)*DW +: DW] = m[((c*H + 2*r+1)*W + 2*x+1)*DW +: DW];
        return o;
    endfunction

    function automatic logic [IN_BITS-1:0] put_win(input logic [IN_BITS-1:0] m,
                                                   input int c, input int r, input int x,
                                                   input logic [15:0] a, input logic [15:0] b,
                                                   input logic [15:0] cc, input logic [15:0] d);
        logic [IN_BITS-1:0] t;
        t = m;
        t[((c*H + 2*r)*W   + 2*x)*DW   +: DW] = a;
        t[((c*H + 2*r)*W   + 2*x+1)*DW +: DW] = b;
        t[((c*H + 2*r+1)*W + 2*x)*DW   +: DW] = cc;
        t[((c*H + 2*r+1)*W + 2*x+1)*DW +: DW] = d;
        return t;
    endfunction

    function automatic logic [OUT_BITS-1:0] put_out(input logic [OUT_BITS-1:0] o,
                                                    input int c, input int r, input int x,
                                                    input logic [15:0] v);
        logic [OUT_BITS-1:0] t;
        t = o;
        t[((c*HO + r)*WO + x)*DW +: DW] = v;
        return t;
    endfunction

    function automatic logic [15:0] pool_at(input int c, input int r, input int x);
        return outputPool[((c*HO + r)*WO + x)*DW +: DW];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    endtask

    // Called just after a negedge: present the map with start high; the next
    // rising edge is the one expected to accept it.
    task automatic applyStimulus(input logic [IN_BITS-1:0] m, input logic [OUT_BITS-1:0] expv);
        exp_t e;
        convIn = m;
        start  = 1'b1;
        @(posedge clk);
        #1;
        e.data       = expv;
        e.done_cycle = cyc + HO;
        sb.push_back(e);
    endtask

    // Wait (bounded) for every queued result to be checked, then step into IDLE.
    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard_drained", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    // Monitor: on each done pulse compare timing, busy length and every element.
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_run++;
        else      busy_run = 0;
        if (done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("done_cycle", cyc, e.done_cycle);
                checkOutput("busy_length", busy_run, HO + 1);
                for (int c = 0; c < C; c++)
                    for (int r = 0; r < HO; r++)
                        for (int x = 0; x < WO; x++)
                            checkOutput($sformatf("pool[%0d][%0d][%0d]", c, r, x),
                                        pool_at(c, r, x),
                                        e.data[((c*HO + r)*WO + x)*DW +: DW]);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [IN_BITS-1:0]  m;
        logic [OUT_BITS-1:0] ev;

        reset  = 1'b1;
        start  = 1'b0;
        convIn = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_pool_ones", $countones(outputPool), 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed windows with hand-computed results; all other windows are +0.
        m  = '0;
        ev = '0;
        m  = put_win(m, 0, 0, 0, 16'h3C00, 16'h4000, 16'hC200, 16'h3800);
        ev = put_out(ev, 0, 0, 0, 16'h4000);
        m  = put_win(m, 1, 3, 4, 16'hBC00, 16'hC000, 16'h8000, 16'hC500);
        ev = put_out(ev, 1, 3, 4, 16'h0000);
        m  = put_win(m, 2, 13, 13, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        ev = put_out(ev, 2, 13, 13, 16'h0000);
        m  = put_win(m, 5, 7, 2, 16'hC000, 16'h0001, 16'h8000, 16'h0000);
        ev = put_out(ev, 5, 7, 2, 16'h0001);
        m  = put_win(m, 3, 5, 6, 16'h1000, 16'h2000, 16'h5000, 16'h4FFF);
        ev = put_out(ev, 3, 5, 6, 16'h5000);
        m  = put_win(m, 5, 13, 13, 16'h3C00, 16'h3C01, 16'h3BFF, 16'h4400);
        ev = put_out(ev, 5, 13, 13, 16'h4400);
        applyStimulus(m, ev);
        start = 1'b0;
        waitDrain(HO + 10);

        // Ramp pass: convIn changes after the start edge and a stray start
        // arrives mid-pass; rows not yet reached still hold the old result.
        m = ramp_map(0);
        applyStimulus(m, ramp_expect(m));
        start  = 1'b0;
        convIn = ramp_map(1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("row0_new", pool_at(0, 0, 0), int_to_fp16(29));
        checkOutput("row13_retained", pool_at(5, 13, 13), 16'h4400);
        waitDrain(HO + 10);

        // Reset sampled 5 edges after the start edge aborts and clears the pass.
        m = ramp_map(2);
        applyStimulus(m, ramp_expect(m));
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_pool_ones", $countones(outputPool), 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_done", done, 0);
        sb.delete();
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(m, ramp_expect(m));
        start = 1'b0;
        waitDrain(HO + 10);

        // Back-to-back: start held high, a new pass every HO+2 edges, each
        // with its own snapshot while convIn is scrambled in between.
        for (int k = 3; k < 6; k++) begin
            m = ramp_map(k);
            applyStimulus(m, ramp_expect(m));
            convIn = ramp_map(k + 4);
            if (k < 5) begin
                repeat (HO + 1) @(posedge clk);
                @(negedge clk);
            end
        end
        start = 1'b0;
        waitDrain(3 * (HO + 2) + 10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
